// File: rtl/disp_scan6.sv
// Six-digit common-anode seven-segment scanner: per-slot dwell plus blank gap,
// frame-wide input snapshot, per-digit blink, decimal points and hours-tens zero blanking.
module disp_scan6 #(
  parameter int DWELL_CYC  = 2,
  parameter int BLANK_CYC  = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg0_in,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [5:0] blink_mask,
  input  logic [5:0] dp_mask,
  input  logic       lz_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  state_t        state_r, state_s;
  logic [2:0]    slot_r, slot_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          adv_s, start_s, frame_s;

  logic [BW-1:0] blink_cnt_r;
  logic          blink_phase_r, blink_lat_r;

  logic [6:0] snap_seg0_r;
  logic [3:0] snap_d1_r, snap_d2_r, snap_d3_r, snap_d4_r, snap_d5_r;
  logic [5:0] snap_blink_r, snap_dp_r;
  logic       snap_lz_r;

  logic [6:0] seg0_s;
  logic [3:0] d1_s, d2_s, d3_s, d4_s, d5_s;
  logic [5:0] bmask_s, dmask_s;
  logic       lz_s;
  logic [3:0] dig_s;
  logic       bm_bit_s, dp_bit_s, phase_s, blank_s;
  logic [5:0] an_s;
  logic [6:0] seg_s;
  logic       dp_s;

  logic [5:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;

  // Scan state register: IDLE only exists between reset release and the first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      slot_r  <= 3'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: dwell/blank sequencing and slot advance with exact 5->0 wrap.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    cnt_s   = cnt_r;
    adv_s   = 1'b0;
    start_s = 1'b0;
    frame_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_DWELL;
        slot_s  = 3'd0;
        cnt_s   = '0;
        start_s = 1'b1;
        frame_s = 1'b1;
      end
      ST_DWELL: begin
        if (cnt_r == DWELL_LAST) begin
          if (BLANK_CYC == 0) begin
            adv_s = 1'b1;
          end else begin
            state_s = ST_BLANK;
            cnt_s   = '0;
          end
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          adv_s = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
        slot_s  = 3'd0;
        cnt_s   = '0;
      end
    endcase
    if (adv_s) begin
      state_s = ST_DWELL;
      cnt_s   = '0;
      start_s = 1'b1;
      if (slot_r == 3'd5) begin
        slot_s  = 3'd0;
        frame_s = 1'b1;
      end else begin
        slot_s = slot_r + 3'd1;
      end
    end else begin
      start_s = start_s;
    end
  end

  // Free-running blink divider; phase latched at every slot start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      blink_lat_r   <= 1'b0;
    end else begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      end
      if (start_s) begin
        blink_lat_r <= blink_phase_r;
      end
    end
  end

  // Frame snapshot, taken on the edge that starts digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_seg0_r  <= 7'd0;
      snap_d1_r    <= 4'd0;
      snap_d2_r    <= 4'd0;
      snap_d3_r    <= 4'd0;
      snap_d4_r    <= 4'd0;
      snap_d5_r    <= 4'd0;
      snap_blink_r <= 6'd0;
      snap_dp_r    <= 6'd0;
      snap_lz_r    <= 1'b0;
    end else if (frame_s) begin
      snap_seg0_r  <= seg0_in;
      snap_d1_r    <= d1;
      snap_d2_r    <= d2;
      snap_d3_r    <= d3;
      snap_d4_r    <= d4;
      snap_d5_r    <= d5;
      snap_blink_r <= blink_mask;
      snap_dp_r    <= dp_mask;
      snap_lz_r    <= lz_en;
    end
  end

  // Output decode for the slot entered on the coming edge; the snapshot
  // being written on that same edge is bypassed from the live inputs.
  always_comb begin
    seg0_s  = frame_s ? seg0_in    : snap_seg0_r;
    d1_s    = frame_s ? d1         : snap_d1_r;
    d2_s    = frame_s ? d2         : snap_d2_r;
    d3_s    = frame_s ? d3         : snap_d3_r;
    d4_s    = frame_s ? d4         : snap_d4_r;
    d5_s    = frame_s ? d5         : snap_d5_r;
    bmask_s = frame_s ? blink_mask : snap_blink_r;
    dmask_s = frame_s ? dp_mask    : snap_dp_r;
    lz_s    = frame_s ? lz_en      : snap_lz_r;
    phase_s = start_s ? blink_phase_r : blink_lat_r;
    dig_s    = 4'd0;
    bm_bit_s = 1'b0;
    dp_bit_s = 1'b0;
    case (slot_s)
      3'd0: begin dig_s = 4'd0; bm_bit_s = bmask_s[0]; dp_bit_s = dmask_s[0]; end
      3'd1: begin dig_s = d1_s; bm_bit_s = bmask_s[1]; dp_bit_s = dmask_s[1]; end
      3'd2: begin dig_s = d2_s; bm_bit_s = bmask_s[2]; dp_bit_s = dmask_s[2]; end
      3'd3: begin dig_s = d3_s; bm_bit_s = bmask_s[3]; dp_bit_s = dmask_s[3]; end
      3'd4: begin dig_s = d4_s; bm_bit_s = bmask_s[4]; dp_bit_s = dmask_s[4]; end
      3'd5: begin dig_s = d5_s; bm_bit_s = bmask_s[5]; dp_bit_s = dmask_s[5]; end
      default: begin dig_s = 4'd0; bm_bit_s = 1'b0; dp_bit_s = 1'b0; end
    endcase
    blank_s = (phase_s & bm_bit_s) |
              ((slot_s == 3'd5) & lz_s & (d5_s == 4'd0));
    if (state_s == ST_DWELL) begin
      an_s  = ~(6'b000001 << slot_s);
      seg_s = blank_s ? 7'd0 : ((slot_s == 3'd0) ? seg0_s : bcd_to_seg(dig_s));
      dp_s  = dp_bit_s & ~(phase_s & bm_bit_s);
    end else begin
      an_s  = 6'b111111;
      seg_s = 7'd0;
      dp_s  = 1'b0;
    end
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 6'b111111;
      seg_r <= 7'd0;
      dp_r  <= 1'b0;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_disp_scan6.sv
// Directed bench for disp_scan6 (DWELL_CYC=2, BLANK_CYC=1, BLINK_HALF=4).
module tb_disp_scan6;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg0_in;
  logic [3:0] d1, d2, d3, d4, d5;
  logic [5:0] blink_mask, dp_mask;
  logic       lz_en;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;

  disp_scan6 #(.DWELL_CYC(2), .BLANK_CYC(1), .BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst), .seg0_in(seg0_in),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d2, d3, d5;
    logic       lz;
    logic [5:0] dpm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [5:0] ea, input logic [6:0] es, input logic ed);
    checks++;
    if ({an, seg, dp} !== {ea, es, ed}) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, an, seg, dp, ea, es, ed);
    end
  endtask

  // Two dwell records plus one blank record for one digit slot.
  task automatic add_slot(input logic [3:0] v2, v3, v5, input logic vlz, input logic [5:0] vdpm,
                          input logic [5:0] ea, input logic [6:0] es, input logic ed);
    vec_t v;
    v.d2 = v2; v.d3 = v3; v.d5 = v5; v.lz = vlz; v.dpm = vdpm;
    v.an = ea; v.seg = es; v.dp = ed;
    vecs.push_back(v);
    vecs.push_back(v);
    v.an = 6'b111111; v.seg = 7'h00; v.dp = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] blink_exp [4];
    logic [6:0] slot_seg  [6];
    int s, w, f;
    logic [5:0] ea;
    logic [6:0] es;
    logic       ed;

    // Frame 1 shows the original values; changes applied at slot 1 appear in frame 2.
    add_slot(4'd2, 4'd3, 4'd2, 1'b0, 6'b000000, 6'b111110, 7'b0111111, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b111101, 7'b0000110, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b111011, 7'b1011011, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b110111, 7'b1001111, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b101111, 7'b1100110, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b011111, 7'b1011011, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b111110, 7'b0111111, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b111101, 7'b0000110, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b111011, 7'b0000111, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b110111, 7'b0000000, 1'b0);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b101111, 7'b1100110, 1'b1);
    add_slot(4'd7, 4'hA, 4'd0, 1'b1, 6'b010000, 6'b011111, 7'b0000000, 1'b0);

    blink_exp[0] = 7'b0000000;
    blink_exp[1] = 7'b1101101;
    blink_exp[2] = 7'b1101101;
    blink_exp[3] = 7'b0000000;

    rst = 1'b0;
    seg0_in = 7'h55; d1 = 4'd9; d2 = 4'd8; d3 = 4'd7; d4 = 4'd6; d5 = 4'd5;
    blink_mask = 6'b111111; dp_mask = 6'b111111; lz_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_hold", 6'b111111, 7'h00, 1'b0);

    seg0_in = 7'b0111111; d1 = 4'd1; d4 = 4'd4;
    blink_mask = 6'b000000;
    d2 = vecs[0].d2; d3 = vecs[0].d3; d5 = vecs[0].d5; lz_en = vecs[0].lz; dp_mask = vecs[0].dpm;
    rst = 1'b1;
    #1;
    chk("release_no_edge", 6'b111111, 7'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      d2 = vecs[i].d2; d3 = vecs[i].d3; d5 = vecs[i].d5;
      lz_en = vecs[i].lz; dp_mask = vecs[i].dpm;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp);
    end

    // Frame 3: leading-zero suppression disabled, d5 still 0.
    lz_en = 1'b0;
    for (int c = 36; c <= 51; c++) begin
      tick();
      if (c == 45) chk("bad_bcd_f3", 6'b110111, 7'h00, 1'b0);
    end
    chk("lz_off", 6'b011111, 7'b0111111, 1'b0);

    for (int c = 52; c <= 63; c++) tick();
    chk("pre_rst_slot3", 6'b110111, 7'h00, 1'b0);

    #2 rst = 1'b0;
    #1;
    chk("async_rst", 6'b111111, 7'h00, 1'b0);
    seg0_in = 7'b1011011; d2 = 4'd5; d3 = 4'd3; d5 = 4'd2; lz_en = 1'b0;
    blink_mask = 6'b000100; dp_mask = 6'b010000;
    repeat (3) @(negedge clk);
    chk("rst_held", 6'b111111, 7'h00, 1'b0);
    rst = 1'b1;

    slot_seg[0] = 7'b1011011;
    slot_seg[1] = 7'b0000110;
    slot_seg[2] = 7'b0000000;
    slot_seg[3] = 7'b1001111;
    slot_seg[4] = 7'b1100110;
    slot_seg[5] = 7'b1011011;
    for (int c = 0; c < 72; c++) begin
      tick();
      f = c / 18;
      s = (c % 18) / 3;
      w = c % 3;
      if (w == 2) begin
        ea = 6'b111111; es = 7'h00; ed = 1'b0;
      end else begin
        ea = ~(6'b000001 << s);
        es = (s == 2) ? blink_exp[f] : slot_seg[s];
        ed = (s == 4);
      end
      chk($sformatf("blink_c%0d", c), ea, es, ed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
